// File: rtl/mcl_useq.sv
// mcl_useq: microcode sequencer for the MCL86 execution unit.
// It generates the microcode ROM address and a per-slot valid. Jumps can be
// immediate, dispatch (shifted opcode field) or return, optionally conditional,
// with a call/return stack that reports its level and a sticky error flag.
// Optional build macro: MCL_USEQ_STACK_TRAP_EN. When it is defined, stack
// overflow on a call or underflow on a return vectors to TRAP_ADDR.
module mcl_useq #(
  parameter int                ADDR_W      = 13,
  parameter int                STACK_DEPTH = 4,
  parameter int                COND_W      = 16,
  parameter int                DISPATCH_W  = 8,
  parameter logic [ADDR_W-1:0] RESET_ADDR  = 13'h0020,
  parameter logic [ADDR_W-1:0] TRAP_ADDR   = 13'h0010
) (
  input  logic                             CORE_CLK_INT,
  input  logic                             RESET_N_INT,
  input  logic                             USEQ_HOLD,
  input  logic                             UJ_VALID,
  input  logic [1:0]                       UJ_SRC,
  input  logic                             UJ_CALL,
  input  logic                             UJ_COND_EN,
  input  logic [$clog2(COND_W)-1:0]        UJ_COND_SEL,
  input  logic                             UJ_COND_POL,
  input  logic [1:0]                       UJ_SHIFT,
  input  logic [ADDR_W-1:0]                UJ_IMM,
  input  logic [COND_W-1:0]                COND_IN,
  input  logic [DISPATCH_W-1:0]            DISPATCH_IN,
  output logic [ADDR_W-1:0]                USEQ_ROM_ADDR,
  output logic                             USEQ_ROM_EN,
  output logic                             USEQ_SLOT_VALID,
  output logic [$clog2(STACK_DEPTH+1)-1:0] USEQ_STACK_LEVEL,
  output logic                             USEQ_STACK_ERR
);

  localparam int SEL_W = $clog2(COND_W);
  localparam int LVL_W = $clog2(STACK_DEPTH+1);
  // Wide enough to hold the dispatch field shifted by the maximum of 3.
  localparam int EW    = ADDR_W + DISPATCH_W + 3;

`ifdef MCL_USEQ_STACK_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              valid_q, valid_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

  logic              slot_valid, cond_bit, taken, push, pop, full, empty, ovf, unf;
  logic [ADDR_W-1:0] top, target, disp_tgt;

  assign slot_valid = valid_q & ~USEQ_HOLD;
  assign full       = (level_q == LVL_W'(STACK_DEPTH));
  assign empty      = (level_q == '0);

  // Condition bit select; an index beyond COND_W matches nothing and reads 0.
  always_comb begin
    cond_bit = 1'b0;
    for (int i = 0; i < COND_W; i++) begin
      if (UJ_COND_SEL == SEL_W'(i)) cond_bit = COND_IN[i];
    end
  end

  // Stack top read; the entry at index level-1 is the most recent push.
  always_comb begin
    top = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (level_q == LVL_W'(i + 1)) top = stack_q[i];
    end
  end

  // Jump decode. Slot valid already excludes hold, so push/pop are frozen too.
  assign taken = slot_valid & UJ_VALID & (UJ_SRC != 2'd3) &
                 (~UJ_COND_EN | (cond_bit ^ UJ_COND_POL));
  assign push  = taken & UJ_CALL & ~UJ_SRC[1];
  assign pop   = taken & (UJ_SRC == 2'd2);
  assign ovf   = push & full;
  assign unf   = pop & empty;

  // Dispatch target: the base keeps the bits outside the shifted field window.
  assign disp_tgt = ADDR_W'((EW'(UJ_IMM) & ~(EW'({DISPATCH_W{1'b1}}) << UJ_SHIFT)) |
                            (EW'(DISPATCH_IN) << UJ_SHIFT));

  // Next-state for address, valid, stack level and the sticky error flag.
  always_comb begin
    addr_d  = addr_q;
    valid_d = valid_q;
    level_d = level_q;
    err_d   = err_q;
    case (UJ_SRC)
      2'd0:    target = UJ_IMM;
      2'd1:    target = disp_tgt;
      default: target = unf ? RESET_ADDR : top;
    endcase
    if (TRAP_EN && (ovf || unf)) target = TRAP_ADDR;
    if (!USEQ_HOLD) begin
      if (taken) begin
        addr_d  = target;
        valid_d = 1'b0;   // squash the fall-through word already fetched
      end else begin
        addr_d  = addr_q + 1'b1;
        valid_d = 1'b1;
      end
      if (push && !full)  level_d = level_q + 1'b1;
      if (pop && !empty)  level_d = level_q - 1'b1;
      if (ovf || unf)     err_d   = 1'b1;
    end
  end

  // Sequencer state registers.
  always_ff @(posedge CORE_CLK_INT or negedge RESET_N_INT) begin
    if (!RESET_N_INT) begin
      addr_q  <= RESET_ADDR;
      valid_q <= 1'b0;
      level_q <= '0;
      err_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      valid_q <= valid_d;
      level_q <= level_d;
      err_q   <= err_d;
    end
  end

  // Stack entries. A normal push writes at index level; an overflowing push
  // shifts every entry down one place, dropping the oldest at index 0.
  genvar gi;
  generate
    for (gi = 0; gi < STACK_DEPTH; gi++) begin : g_stack
      logic [ADDR_W-1:0] ent_q, ent_d, shift_in;

      if (gi == STACK_DEPTH - 1) begin : g_top
        assign shift_in = addr_q;
      end else begin : g_mid
        assign shift_in = stack_q[gi+1];
      end

      // Select what this entry holds after the cycle.
      always_comb begin
        ent_d = ent_q;
        if (push) begin
          if (full)                          ent_d = shift_in;
          else if (level_q == LVL_W'(gi))    ent_d = addr_q;
        end
      end

      // Entry storage.
      always_ff @(posedge CORE_CLK_INT or negedge RESET_N_INT) begin
        if (!RESET_N_INT) ent_q <= '0;
        else              ent_q <= ent_d;
      end

      assign stack_q[gi] = ent_q;
    end
  endgenerate

  assign USEQ_ROM_ADDR    = addr_q;
  assign USEQ_ROM_EN      = ~USEQ_HOLD;
  assign USEQ_SLOT_VALID  = slot_valid;
  assign USEQ_STACK_LEVEL = level_q;
  assign USEQ_STACK_ERR   = err_q;

endmodule

// File: tb/tb_mcl_useq.sv
// Directed testbench for mcl_useq with default parameters.
module tb_mcl_useq;

`ifdef MCL_USEQ_STACK_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hold = 1'b0;
  logic        uj_valid = 1'b0, uj_call = 1'b0, uj_cond_en = 1'b0, uj_cond_pol = 1'b0;
  logic [1:0]  uj_src = '0, uj_shift = '0;
  logic [3:0]  uj_cond_sel = '0;
  logic [12:0] uj_imm = '0;
  logic [15:0] cond_in = '0;
  logic [7:0]  dispatch_in = '0;
  logic [12:0] rom_addr;
  logic        rom_en, slot_valid, stack_err;
  logic [2:0]  level;

  int checks = 0;
  int errors = 0;

  mcl_useq dut (
    .CORE_CLK_INT     (clk),
    .RESET_N_INT      (rst_n),
    .USEQ_HOLD        (hold),
    .UJ_VALID         (uj_valid),
    .UJ_SRC           (uj_src),
    .UJ_CALL          (uj_call),
    .UJ_COND_EN       (uj_cond_en),
    .UJ_COND_SEL      (uj_cond_sel),
    .UJ_COND_POL      (uj_cond_pol),
    .UJ_SHIFT         (uj_shift),
    .UJ_IMM           (uj_imm),
    .COND_IN          (cond_in),
    .DISPATCH_IN      (dispatch_in),
    .USEQ_ROM_ADDR    (rom_addr),
    .USEQ_ROM_EN      (rom_en),
    .USEQ_SLOT_VALID  (slot_valid),
    .USEQ_STACK_LEVEL (level),
    .USEQ_STACK_ERR   (stack_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_av(input string tag, input logic [12:0] a, input logic v);
    chk({tag, ".addr"}, rom_addr, a);
    chk({tag, ".valid"}, slot_valid, v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    uj_valid = 0; uj_call = 0; uj_cond_en = 0; uj_cond_pol = 0;
    uj_src = 0; uj_shift = 0; uj_cond_sel = 0; uj_imm = 0;
  endtask

  task automatic jmp(input logic [1:0] src, input logic call, input logic [12:0] imm);
    uj_valid = 1; uj_src = src; uj_call = call; uj_imm = imm; uj_cond_en = 0;
  endtask

  initial begin
    logic [12:0] exp_a;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_av("rst", 13'h0020, 1'b0);
    chk("rst.level", level, 3'd0);
    chk("rst.err", stack_err, 1'b0);
    chk("rst.rom_en", rom_en, 1'b1);
    rst_n = 1;
    $display("step: reset released");
    chk_av("seq0", 13'h0020, 1'b0);
    tick(); chk_av("seq1", 13'h0021, 1'b1);
    tick(); chk_av("seq2", 13'h0022, 1'b1);
    tick(); chk_av("seq3", 13'h0023, 1'b1);

    // Conditional jump, bit 3 set, polarity 0: taken
    jmp(0, 0, 13'h0400); uj_cond_en = 1; uj_cond_sel = 4'd3; cond_in = 16'h0008;
    tick(); idle();
    $display("step: conditional jump taken");
    chk_av("cj_bub", 13'h0400, 1'b0);
    tick(); chk_av("cj_tgt", 13'h0401, 1'b1);
    // Same with bit 3 clear: falls through
    jmp(0, 0, 13'h0400); uj_cond_en = 1; uj_cond_sel = 4'd3; cond_in = 16'h0000;
    tick(); idle();
    $display("step: conditional jump not taken");
    chk_av("cj_nt", 13'h0402, 1'b1);
    // Polarity 1 with bit 3 clear: taken
    jmp(0, 0, 13'h0500); uj_cond_en = 1; uj_cond_sel = 4'd3; uj_cond_pol = 1;
    tick(); idle();
    $display("step: inverted-polarity jump");
    chk_av("cj_pol", 13'h0500, 1'b0);
    tick(); chk_av("cj_pol_tgt", 13'h0501, 1'b1);

    // Dispatch
    jmp(1, 0, 13'h0800); dispatch_in = 8'hA5; uj_shift = 2'd2;
    tick(); idle();
    $display("step: dispatch shift 2");
    chk_av("disp2", 13'h0A94, 1'b0);
    tick(); chk_av("disp2_tgt", 13'h0A95, 1'b1);
    jmp(1, 0, 13'h0800); uj_shift = 2'd0;
    tick();
    $display("step: dispatch shift 0");
    chk_av("disp0", 13'h08A5, 1'b0);
    // A jump field during the bubble must be ignored
    jmp(0, 0, 13'h0123);
    tick(); idle();
    chk_av("bubble_ign", 13'h08A6, 1'b1);

    // Call from 0x0100 to 0x0300 and return
    jmp(0, 0, 13'h0100); tick(); idle(); tick();
    chk_av("pre_call", 13'h0101, 1'b1);
    jmp(0, 1, 13'h0300); tick(); idle();
    $display("step: call 0x0100 -> 0x0300");
    chk_av("call", 13'h0300, 1'b0);
    chk("call.level", level, 3'd1);
    tick(); chk_av("call_tgt", 13'h0301, 1'b1);
    jmp(2, 0, 13'h0000); tick(); idle();
    $display("step: return");
    chk_av("ret", 13'h0101, 1'b0);
    chk("ret.level", level, 3'd0);
    tick(); chk_av("ret_tgt", 13'h0102, 1'b1);
    chk("ret.err", stack_err, 1'b0);

    // Not-taken call must not push
    jmp(0, 1, 13'h0777); uj_cond_en = 1; uj_cond_sel = 4'd5; cond_in = 16'h0000;
    tick(); idle();
    $display("step: not-taken call");
    chk_av("nt_call", 13'h0103, 1'b1);
    chk("nt_call.level", level, 3'd0);

    // Five nested calls; the fifth overflows. Pushed: 0x103(dropped),0x201,0x211,0x221,0x231
    for (int i = 0; i < 5; i++) begin
      jmp(0, 1, 13'h0200 + 13'(i * 16)); tick(); idle();
      exp_a = (i == 4 && TRAP) ? 13'h0010 : 13'h0200 + 13'(i * 16);
      $display("step: nested call %0d", i + 1);
      chk_av("ncall", exp_a, 1'b0);
      chk("ncall.level", level, (i < 4) ? 32'(i + 1) : 32'd4);
      chk("ncall.err", stack_err, (i == 4) ? 1'b1 : 1'b0);
      tick(); chk_av("ncall_tgt", exp_a + 13'd1, 1'b1);
    end
    for (int j = 0; j < 4; j++) begin
      jmp(2, 0, 13'h0000); tick(); idle();
      exp_a = 13'h0231 - 13'(j * 16);
      $display("step: nested return %0d", j + 1);
      chk_av("nret", exp_a, 1'b0);
      chk("nret.level", level, 32'(3 - j));
      tick(); chk_av("nret_tgt", exp_a + 13'd1, 1'b1);
    end
    // Underflow return
    jmp(2, 0, 13'h0000); tick(); idle();
    exp_a = TRAP ? 13'h0010 : 13'h0020;
    $display("step: underflow return");
    chk_av("unf", exp_a, 1'b0);
    chk("unf.level", level, 3'd0);
    chk("unf.err", stack_err, 1'b1);
    tick(); chk_av("unf_tgt", exp_a + 13'd1, 1'b1);

    // Hold over a jump word for 3 cycles
    exp_a = rom_addr;
    hold = 1; jmp(0, 0, 13'h0600);
    #1;
    $display("step: hold asserted");
    chk("hold.valid", slot_valid, 1'b0);
    chk("hold.rom_en", rom_en, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_av("hold", exp_a, 1'b0);
      chk("hold.rom_en", rom_en, 1'b0);
    end
    hold = 0;
    #1;
    chk("rel.valid", slot_valid, 1'b1);
    chk("rel.rom_en", rom_en, 1'b1);
    tick(); idle();
    $display("step: hold released, jump executes");
    chk_av("hold_jmp", 13'h0600, 1'b0);
    tick(); chk_av("hold_tgt", 13'h0601, 1'b1);
    tick(); chk_av("hold_seq", 13'h0602, 1'b1);

    // Reset asserted mid-hold
    jmp(0, 1, 13'h0700); tick(); idle();
    chk("pre_rst.level", level, 3'd1);
    tick(); chk_av("pre_rst", 13'h0701, 1'b1);
    hold = 1; jmp(0, 1, 13'h07A0);
    tick();
    chk_av("hold2", 13'h0701, 1'b0);
    chk("hold2.level", level, 3'd1);
    #2 rst_n = 0;
    #1;
    $display("step: reset mid-hold");
    chk_av("mid_rst", 13'h0020, 1'b0);
    chk("mid_rst.level", level, 3'd0);
    chk("mid_rst.err", stack_err, 1'b0);
    hold = 0; idle();
    tick();
    rst_n = 1;
    chk_av("rst2_c0", 13'h0020, 1'b0);
    tick(); chk_av("rst2_c1", 13'h0021, 1'b1);

    // Address wrap
    jmp(0, 0, 13'h1FFF); tick(); idle();
    $display("step: address wrap");
    chk_av("wrap_bub", 13'h1FFF, 1'b0);
    tick(); chk_av("wrap0", 13'h0000, 1'b1);
    tick(); chk_av("wrap1", 13'h0001, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
